// File: rtl/fx_match_pipe.sv
// fx_match_pipe: fixed-point format converter with rounding, overflow
// handling, a valid-qualified delay pipeline and an overflow event counter.
//
// Handshake: i_valid qualifies i_data on every rising edge of i_clk and is
// always accepted (no backpressure). o_valid qualifies o_data/o_ovf exactly
// DELAY cycles later. While o_valid is low, o_data/o_ovf hold the last
// valid result.
module fx_match_pipe #(
    parameter int IN_W       = 13,
    parameter int IN_FRAC    = 8,
    parameter int OUT_W      = 13,
    parameter int OUT_FRAC   = 8,
    parameter int SIGNED     = 1,
    parameter int ROUND_MODE = 0,
    parameter int OVF_MODE   = 1,
    parameter int DELAY      = 1,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [IN_W-1:0]   i_data,
    input  logic              i_cnt_clr,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_ovf,
    output logic [CNT_W-1:0]  o_ovf_cnt
);

    // Number of LSBs dropped (positive) or zero bits appended (negative).
    localparam int D   = IN_FRAC - OUT_FRAC;
    localparam int SHL = (D < 0) ? -D : 0;

    // Bits needed to hold every possible quantized value. Rounding can carry
    // one position past the truncated width.
    localparam int NEED_W = (D <= 0) ? (IN_W + SHL)
                          : ((ROUND_MODE == 0) ? (IN_W - D) : (IN_W - D + 1));

    // Working width: wide enough for the shifted/rounded value plus a guard
    // bit, and always wider than the output so range compares are exact.
    localparam int Q_W0 = IN_W + SHL + 2;
    localparam int Q_W  = (Q_W0 > OUT_W + 1) ? Q_W0 : (OUT_W + 1);

    // When the output can represent every quantized value there is nothing
    // to compare against, so the overflow stage reduces to wiring.
    localparam bit NO_OVF = (OUT_W >= NEED_W);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    generate
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("fx_match_pipe: DELAY must be in 1..16");
        end
        if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_round
            $error("fx_match_pipe: ROUND_MODE must be 0, 1 or 2");
        end
        if (OUT_W < 2) begin : g_bad_out_w
            $error("fx_match_pipe: OUT_W must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input extension
    // ------------------------------------------------------------------
    logic                 sign_bit;
    logic signed [Q_W-1:0] ext;

    assign sign_bit = (SIGNED != 0) ? i_data[IN_W-1] : 1'b0;
    assign ext      = {{(Q_W-IN_W){sign_bit}}, i_data};

    // ------------------------------------------------------------------
    // Quantization (LSB end)
    // ------------------------------------------------------------------
    logic signed [Q_W-1:0] q_val;

    generate
        if (D <= 0) begin : g_shift_left
            // Gaining fraction bits is exact: zero fill on the right.
            assign q_val = ext <<< SHL;
        end else begin : g_drop
            logic signed [Q_W-1:0] floor_val;

            // Arithmetic shift gives floor for signed and plain shift for
            // unsigned (ext is zero-extended in that case).
            assign floor_val = ext >>> D;

            if (ROUND_MODE == 0) begin : g_trunc
                assign q_val = floor_val;
            end else begin : g_round
                localparam logic [Q_W-1:0] HALF_Q   = Q_W'(1) << (D - 1);
                localparam logic [Q_W-1:0] LOW_MASK = (Q_W'(1) << D) - Q_W'(1);

                logic [Q_W-1:0] rem_q;
                logic           round_up;

                // Remainder is the dropped LSBs, always non-negative.
                assign rem_q = ext & LOW_MASK;

                if (ROUND_MODE == 1) begin : g_half_up
                    assign round_up = (rem_q >= HALF_Q);
                end else begin : g_convergent
                    // Ties go to the even neighbour.
                    assign round_up = (rem_q > HALF_Q) ||
                                      ((rem_q == HALF_Q) && floor_val[0]);
                end

                assign q_val = floor_val + $signed({{(Q_W-1){1'b0}}, round_up});
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Overflow handling (MSB end)
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] conv_data;
    logic             conv_ovf;

    generate
        if (NO_OVF) begin : g_no_ovf
            assign conv_data = q_val[OUT_W-1:0];
            assign conv_ovf  = 1'b0;
        end else begin : g_ovf
            localparam logic signed [Q_W-1:0] MAX_V = (SIGNED != 0)
                ? {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}
                : {{(Q_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
            localparam logic signed [Q_W-1:0] MIN_V = (SIGNED != 0)
                ? {{(Q_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}
                : {Q_W{1'b0}};

            logic above;
            logic below;

            assign above    = (q_val > MAX_V);
            assign below    = (q_val < MIN_V);
            assign conv_ovf = above | below;

            if (OVF_MODE == 0) begin : g_wrap
                assign conv_data = q_val[OUT_W-1:0];
            end else begin : g_sat
                // Clamp out-of-range values to the nearest representable bound.
                always_comb begin
                    conv_data = q_val[OUT_W-1:0];
                    if (above) begin
                        conv_data = MAX_V[OUT_W-1:0];
                    end else if (below) begin
                        conv_data = MIN_V[OUT_W-1:0];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Delay pipeline
    // ------------------------------------------------------------------
    logic [DELAY-1:0] valid_pipe;
    logic [DELAY-1:0] ovf_pipe;
    logic [OUT_W-1:0] data_pipe [DELAY];

    // Valid shifts every cycle; payload stages load only behind a valid bit
    // so bubbles (and any X on i_data) never disturb the held result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_pipe <= '0;
            ovf_pipe   <= '0;
            for (int s = 0; s < DELAY; s++) begin
                data_pipe[s] <= '0;
            end
        end else begin
            valid_pipe[0] <= i_valid;
            if (i_valid) begin
                data_pipe[0] <= conv_data;
                ovf_pipe[0]  <= conv_ovf;
            end
            for (int s = 1; s < DELAY; s++) begin
                valid_pipe[s] <= valid_pipe[s-1];
                if (valid_pipe[s-1]) begin
                    data_pipe[s] <= data_pipe[s-1];
                    ovf_pipe[s]  <= ovf_pipe[s-1];
                end
            end
        end
    end

    assign o_valid = valid_pipe[DELAY-1];
    assign o_data  = data_pipe[DELAY-1];
    assign o_ovf   = ovf_pipe[DELAY-1];

    // ------------------------------------------------------------------
    // Overflow event counter
    // ------------------------------------------------------------------
    logic ovf_event;

    assign ovf_event = o_valid & o_ovf;

    // Saturating count of flagged outputs; a clear that coincides with an
    // event keeps that event, so the count restarts at 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ovf_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_ovf_cnt <= ovf_event ? CNT_W'(1) : '0;
        end else if (ovf_event && (o_ovf_cnt != CNT_MAX)) begin
            o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
        end
    end

endmodule
